// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over req/ready and
// presents {pc, pc_4, instr} to IF/ID, discarding wrong-path reads on redirects.
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [31:0] instr,
  output logic        fetch_valid,
  output logic        fetch_stall,
  output logic        imem_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] pc_reg_q, pc_reg_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_4_q, pc_4_d;
  logic [31:0] instr_q, instr_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        imem_err_q, imem_err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        req;
  logic        redirect;
  logic        consume;
  logic [31:0] target;

  // Branch wins over jump; targets are always word aligned.
  assign redirect = branch_taken | jump;
  assign target   = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
  assign consume  = fetch_valid_q & pc_write;

  always_comb begin
    state_d       = state_q;
    pc_reg_d      = pc_reg_q;
    redirect_pc_d = redirect_pc_q;
    pc_d          = pc_q;
    pc_4_d        = pc_4_q;
    instr_d       = instr_q;
    fetch_valid_d = fetch_valid_q;
    wait_cnt_d    = wait_cnt_q;
    imem_err_d    = imem_err_q;
    req           = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_reg_d = target;
      end
      REQ: begin
        req = 1'b1;
        if (imem_ready && !redirect) begin
          pc_d          = pc_reg_q;
          pc_4_d        = pc_reg_q + 32'd4;
          instr_d       = imem_rdata;
          fetch_valid_d = 1'b1;
          state_d       = HOLD;
        end else if (imem_ready) begin
          pc_reg_d = target;
        end else if (redirect) begin
          // Read is still in flight; the address must stay put until it returns.
          redirect_pc_d = target;
          state_d       = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          fetch_valid_d = 1'b0;
          pc_reg_d      = target;
          state_d       = REQ;
        end else if (consume) begin
          fetch_valid_d = 1'b0;
          pc_reg_d      = pc_reg_q + 32'd4;
          state_d       = REQ;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (imem_ready) begin
          pc_reg_d = redirect ? target : redirect_pc_q;
          state_d  = REQ;
        end else if (redirect) begin
          redirect_pc_d = target;
        end
      end
      default: state_d = IDLE;
    endcase

    // Saturating watchdog on outstanding reads; error is sticky.
    if (imem_ready) begin
      wait_cnt_d = 8'd0;
    end else if (req && wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    if (req && !imem_ready && wait_cnt_q == LIMIT - 8'd1) imem_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_reg_q      <= RESET_PC;
      redirect_pc_q <= 32'd0;
      pc_q          <= 32'd0;
      pc_4_q        <= 32'd0;
      instr_q       <= 32'd0;
      fetch_valid_q <= 1'b0;
      imem_err_q    <= 1'b0;
      wait_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      pc_reg_q      <= pc_reg_d;
      redirect_pc_q <= redirect_pc_d;
      pc_q          <= pc_d;
      pc_4_q        <= pc_4_d;
      instr_q       <= instr_d;
      fetch_valid_q <= fetch_valid_d;
      imem_err_q    <= imem_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = pc_reg_q;
  assign pc          = pc_q;
  assign pc_4        = pc_4_q;
  assign instr       = instr_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_stall = ~fetch_valid_q;
  assign imem_err    = imem_err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a small memory responder feeds a scoreboard of expected
// {pc, pc_4, instr} triples, checked when each new fetch is presented.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic [31:0] instr;
  logic        fetch_valid;
  logic        fetch_stall;
  logic        imem_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   mem_wait = 0;
  int   wcnt = 0;
  bit   mem_hang = 1'b0;
  bit   drop_resp = 1'b0;
  bit   fv_prev = 1'b0;

  pc_fetch #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .pc_4(pc_4), .instr(instr),
    .fetch_valid(fetch_valid), .fetch_stall(fetch_stall), .imem_err(imem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with this cycle's control inputs already driven.
  task automatic tick();
    exp_t e;
    if (imem_req && !mem_hang && wcnt >= mem_wait) begin
      imem_ready = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wcnt = 0;
      if (drop_resp) drop_resp = 1'b0;
      else if (!(branch_taken || jump)) begin
        e.pc    = imem_addr;
        e.pc4   = imem_addr + 32'd4;
        e.instr = mem_word(imem_addr);
        sb_q.push_back(e);
      end
    end else begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (imem_req) begin
        wcnt++;
        if (branch_taken || jump) drop_resp = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    if (fetch_valid && !fv_prev) begin
      chk1("sb_nonempty", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_pc_4", pc_4, e.pc4);
        chk("sb_instr", instr, e.instr);
      end
    end
    fv_prev = fetch_valid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pc_write = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'd0; jump_target = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pc_4", pc_4, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk1("rst_valid", fetch_valid, 1'b0);
    chk1("rst_stall", fetch_stall, 1'b1);
    chk1("rst_err", imem_err, 1'b0);
    reset = 1'b1;

    // 1: zero-wait sequential fetch
    pc_write = 1'b1;
    chk1("idle_req", imem_req, 1'b0);
    tick();
    chk("t1_addr0", imem_addr, 32'h0);
    chk1("t1_req0", imem_req, 1'b1);
    chk1("t1_fv_req", fetch_valid, 1'b0);
    tick();
    chk1("t1_fv_hold", fetch_valid, 1'b1);
    chk1("t1_stall_hold", fetch_stall, 1'b0);
    chk1("t1_req_hold", imem_req, 1'b0);
    tick();
    chk("t1_addr4", imem_addr, 32'h4);
    chk1("t1_fv_gap", fetch_valid, 1'b0);
    chk1("t1_stall_gap", fetch_stall, 1'b1);
    tick();
    tick();
    chk("t1_addr8", imem_addr, 32'h8);
    tick();

    // 2: stall in HOLD
    pc_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("t2_fv", fetch_valid, 1'b1);
      chk1("t2_req", imem_req, 1'b0);
      chk("t2_pc", pc, 32'h8);
      chk("t2_instr", instr, mem_word(32'h8));
    end
    pc_write = 1'b1;
    tick();
    chk("t2_addr_next", imem_addr, 32'hC);
    tick();

    // 3: redirect during a wait-stated read
    mem_wait = 3;
    tick();
    chk("t3_addr_a", imem_addr, 32'h10);
    tick();
    chk("t3_addr_b", imem_addr, 32'h10);
    chk1("t3_req_b", imem_req, 1'b1);
    jump = 1'b1; jump_target = 32'h0000_0103;
    tick();
    jump = 1'b0;
    chk("t3_addr_c", imem_addr, 32'h10);
    chk1("t3_req_c", imem_req, 1'b1);
    chk1("t3_fv_c", fetch_valid, 1'b0);
    tick();
    chk("t3_addr_d", imem_addr, 32'h10);
    tick();
    chk("t3_addr_new", imem_addr, 32'h100);
    chk1("t3_fv_drop", fetch_valid, 1'b0);
    mem_wait = 0;
    tick();
    chk1("t3_fv_new", fetch_valid, 1'b1);
    chk("t3_pc_new", pc, 32'h100);

    // 4: branch and jump together in HOLD, consume also requested
    branch_taken = 1'b1; branch_target = 32'h40;
    jump = 1'b1; jump_target = 32'h80;
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    chk1("t4_fv_flush", fetch_valid, 1'b0);
    chk("t4_addr", imem_addr, 32'h40);
    tick();
    chk("t4_pc", pc, 32'h40);

    // 6: address wrap-around
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_pc_4_wrap", pc_4, 32'h0);
    tick();
    chk("t6_addr_wrap", imem_addr, 32'h0);

    // 5: memory timeout, sticky error, reset mid-wait
    mem_hang = 1'b1;
    repeat (15) tick();
    chk1("t5_err_before", imem_err, 1'b0);
    tick();
    chk1("t5_err_set", imem_err, 1'b1);
    chk1("t5_req_wait", imem_req, 1'b1);
    chk("t5_addr_wait", imem_addr, 32'h0);
    mem_hang = 1'b0;
    tick();
    chk1("t5_err_sticky", imem_err, 1'b1);
    chk1("t5_fv", fetch_valid, 1'b1);
    tick();
    chk("t5_addr4", imem_addr, 32'h4);
    mem_hang = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk1("t5_rst_req", imem_req, 1'b0);
    chk1("t5_rst_err", imem_err, 1'b0);
    chk1("t5_rst_fv", fetch_valid, 1'b0);
    chk("t5_rst_pc", pc, 32'h0);
    chk("t5_rst_addr", imem_addr, 32'h0);
    sb_q.delete();
    drop_resp = 1'b0; fv_prev = 1'b0; wcnt = 0; mem_hang = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("t5_addr_restart", imem_addr, 32'h0);
    chk1("t5_req_restart", imem_req, 1'b1);
    tick();
    chk1("t5_fv_restart", fetch_valid, 1'b1);
    chk1("sb_drained", sb_q.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
